// File: rtl/approx_mul_err_eval.sv
// Exhaustive 8x8 sweep that drives an approximate multiplier and accumulates
// error statistics (count, max, sum, first worst pair) against the exact product.
module approx_mul_err_eval #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  input  logic [15:0] prod_in,
  output logic        busy,
  output logic        done,
  output logic [16:0] err_cnt,
  output logic [15:0] max_err,
  output logic [31:0] sum_err,
  output logic [7:0]  worst_a,
  output logic [7:0]  worst_b
);

  localparam int unsigned PD         = (LAT == 0) ? 1 : LAT;
  localparam logic [2:0]  DRAIN_LAST = (LAT == 0) ? 3'd0 : 3'(LAT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state, state_nx;
  logic [15:0] idx;
  logic [2:0]  dcnt;
  logic [PD-1:0] pv;
  logic [15:0] pp [PD];

  logic        in_sweep_c, start_acc_c, kill_c, cmp_v_c, acc_en_c;
  logic [15:0] cmp_pair_c, exact_c, err_c;
  logic [16:0] diff_c;

  // idx is the pair currently presented; it also holds the last pair outside RUN
  assign op_a = idx[15:8];
  assign op_b = idx[7:0];

  assign in_sweep_c  = (state == S_RUN) || (state == S_DRAIN);
  assign start_acc_c = (state == S_IDLE) && (state_nx == S_RUN);
  assign kill_c      = in_sweep_c && abort;

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start && !abort) state_nx = S_RUN;
      S_RUN: begin
        if (abort)                  state_nx = S_IDLE;
        else if (idx == 16'hFFFF)   state_nx = (LAT == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                  state_nx = S_IDLE;
        else if (dcnt == DRAIN_LAST) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Comparison point: delayed pair meets the returned product
  always_comb begin
    cmp_v_c    = (LAT == 0) ? (state == S_RUN) : pv[PD-1];
    cmp_pair_c = (LAT == 0) ? idx : pp[PD-1];
    exact_c    = 16'(cmp_pair_c[15:8]) * 16'(cmp_pair_c[7:0]);
    diff_c     = (exact_c >= prod_in) ? (17'(exact_c) - 17'(prod_in))
                                      : (17'(prod_in) - 17'(exact_c));
    err_c      = 16'(diff_c);
    acc_en_c   = cmp_v_c && in_sweep_c && !abort;
  end

  // Operand-tracking pipeline matching the multiplier latency
  always_ff @(posedge clk) begin
    if (rst || start_acc_c || kill_c) begin
      pv <= '0;
    end else begin
      pv[0] <= (state == S_RUN);
      for (int k = 1; k < int'(PD); k++) pv[k] <= pv[k-1];
    end
  end

  always_ff @(posedge clk) begin
    pp[0] <= idx;
    for (int k = 1; k < int'(PD); k++) pp[k] <= pp[k-1];
  end

  // State, sweep index and accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      idx     <= '0;
      dcnt    <= '0;
      err_cnt <= '0;
      max_err <= '0;
      sum_err <= '0;
      worst_a <= '0;
      worst_b <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == S_RUN) || (state_nx == S_DRAIN);
      done  <= (state_nx == S_DONE);
      if (start_acc_c) begin
        idx     <= '0;
        dcnt    <= '0;
        err_cnt <= '0;
        max_err <= '0;
        sum_err <= '0;
        worst_a <= '0;
        worst_b <= '0;
      end else begin
        if ((state == S_RUN) && (state_nx == S_RUN)) idx <= idx + 16'd1;
        dcnt <= (state == S_DRAIN) ? dcnt + 3'd1 : 3'd0;
        if (acc_en_c) begin
          err_cnt <= err_cnt + 17'(err_c != 16'd0);
          sum_err <= sum_err + 32'(err_c);
          if (err_c > max_err) begin
            max_err <= err_c;
            worst_a <= cmp_pair_c[15:8];
            worst_b <= cmp_pair_c[7:0];
          end
        end
      end
    end
  end

endmodule
